// File: rtl/if_pkg.sv
// Shared types and RISC-V opcode classification for the instruction-fetch cache.
// No ports: a package of the fetch FSM state enum, opcode constants and the decode helper functions.
// Helper functions are purely combinational and look only at the major opcode and the word value.
package if_pkg;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MISS_REQ  = 2'd1,
    S_MISS_FILL = 2'd2,
    S_REPLAY    = 2'd3
  } if_state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_REG32  = 7'h3B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  function automatic logic writes_rd(input logic [31:0] ins);
    return ins[6:0] inside {OP_LOAD, OP_IMM, OP_IMM32, OP_AUIPC, OP_LUI, OP_REG, OP_REG32};
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ins);
    return ins[6:0] inside {OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_REG, OP_REG32, OP_BRANCH};
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ins);
    return ins[6:0] inside {OP_STORE, OP_REG, OP_REG32, OP_BRANCH};
  endfunction

  // An all-zero word is an illegal instruction, so it ends the bundle like a control transfer.
  function automatic logic is_terminator(input logic [31:0] ins);
    return (ins[6:0] inside {OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM}) || (ins == 32'd0);
  endfunction

endpackage

// File: rtl/if_bundle_pick.sv
// Bundle builder: picks up to FETCH_W consecutive words from one cache line starting at off_i.
// Ports: line_i (whole line, word 0 in low bits), off_i (word offset), line_vld_i, instr_o, count_o.
// Latency: purely combinational; no backpressure (the caller registers the result).
module if_bundle_pick
  import if_pkg::*;
#(
  parameter int WORDS   = 16,
  parameter int FETCH_W = 2,
  parameter int OFF_W   = 4,
  parameter int CNT_W   = 2
) (
  input  logic [32*WORDS-1:0]  line_i,
  input  logic [OFF_W-1:0]     off_i,
  input  logic                 line_vld_i,
  output logic [32*FETCH_W-1:0] instr_o,
  output logic [CNT_W-1:0]     count_o
);

  logic [31:0] rd_busy;  // registers written by slots already placed in the bundle
  logic [31:0] cur;
  logic [31:0] prev;
  logic        stop;
  int          idx;

  always_comb begin
    instr_o = '0;
    count_o = '0;
    rd_busy = '0;
    cur     = '0;
    prev    = '0;
    stop    = 1'b0;
    idx     = 0;
    if (line_vld_i) begin
      for (int k = 0; k < FETCH_W; k++) begin
        idx = int'(off_i) + k;
        cur = '0;
        if (idx < WORDS) cur = line_i[32*idx +: 32];
        // Once a slot is dropped every later slot is dropped too.
        if (k > 0 && (idx >= WORDS || is_terminator(prev) ||
                      (uses_rs1(cur) && rd_busy[cur[19:15]]) ||
                      (uses_rs2(cur) && rd_busy[cur[24:20]])))
          stop = 1'b1;
        if (!stop) begin
          instr_o[32*k +: 32] = cur;
          count_o = count_o + CNT_W'(1);
          if (writes_rd(cur) && cur[11:7] != 5'd0) rd_busy[cur[11:7]] = 1'b1;
          prev = cur;
        end
      end
    end
  end

endmodule

// File: rtl/if_fetch_cache.sv
// Instruction-fetch stage: N-way set-associative I-cache with true-LRU, blocking refill and bundle builder.
// Ports: pc_valid/pc/pc_ready request, flush, inv_all, out_* bundle to decode, mem_req_*/mem_resp_* refill, miss.
// Hit: 1 cycle; miss: refill then one REPLAY cycle. Stalled bundle holds all out_* and drops pc_ready.
module if_fetch_cache
  import if_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 64,
  parameter int FETCH_W    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pc_valid,
  input  logic [63:0]                   pc,
  output logic                          pc_ready,
  input  logic                          flush,
  input  logic                          inv_all,
  output logic                          out_valid,
  output logic [63:0]                   out_pc,
  output logic [32*FETCH_W-1:0]         out_instr,
  output logic [$clog2(FETCH_W+1)-1:0]  out_count,
  input  logic                          out_ready,
  output logic                          mem_req_valid,
  output logic [63:0]                   mem_req_addr,
  input  logic                          mem_req_ready,
  input  logic                          mem_resp_valid,
  input  logic [63:0]                   mem_resp_data,
  output logic                          miss
);

  localparam int WORDS  = LINE_BYTES / 4;
  localparam int BEATS  = LINE_BYTES / 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 64 - OFF_W - IDX_W;
  localparam int SET_W  = (SETS > 1) ? IDX_W : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W  = WAY_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(FETCH_W + 1);

  function automatic logic [SET_W-1:0] set_of(input logic [63:0] a);
    return SET_W'((a >> OFF_W) & 64'(SETS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [63:0] a);
    return TAG_W'(a >> (OFF_W + IDX_W));
  endfunction

  // Cache arrays
  logic [63:0]      data_q  [WAYS][SETS][BEATS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];

  // FSM and output registers
  if_state_e             state_q, state_d;
  logic [63:0]           pc_q, pc_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [63:0]           out_pc_q, out_pc_d;
  logic [32*FETCH_W-1:0] out_instr_q, out_instr_d;
  logic [CNT_W-1:0]      out_count_q, out_count_d;

  // Control pulses from the next-state logic
  logic             inv_now, fill_we, fill_done, lru_upd;
  logic [SET_W-1:0] lru_set;
  logic [WAY_W-1:0] lru_way;

  // Lookup: RUN looks at the incoming pc, REPLAY at the latched miss pc.
  logic [63:0]           lk_pc;
  logic [SET_W-1:0]      lk_set;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [WAY_W-1:0]      lk_way;
  logic [32*WORDS-1:0]   lk_line;
  logic [32*FETCH_W-1:0] pick_instr;
  logic [CNT_W-1:0]      pick_cnt;
  logic                  accept;

  assign lk_pc  = (state_q == S_REPLAY) ? pc_q : pc;
  assign lk_set = set_of(lk_pc);
  assign lk_tag = tag_of(lk_pc);

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[lk_set][w] && tag_q[w][lk_set] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    lk_line = '0;
    for (int b = 0; b < BEATS; b++) lk_line[64*b +: 64] = data_q[lk_way][lk_set][b];
  end

  if_bundle_pick #(
    .WORDS  (WORDS),
    .FETCH_W(FETCH_W),
    .OFF_W  (OFF_W - 2),
    .CNT_W  (CNT_W)
  ) u_pick (
    .line_i    (lk_line),
    .off_i     (lk_pc[OFF_W-1:2]),
    .line_vld_i(lk_hit),
    .instr_o   (pick_instr),
    .count_o   (pick_cnt)
  );

  // Victim: lowest invalid way, otherwise the oldest. Ages form a permutation of 0..WAYS-1,
  // so the oldest way is the one holding WAYS-1.
  logic [SET_W-1:0] fill_set;
  logic [WAY_W-1:0] victim;
  logic             found_inv;

  assign fill_set = set_of(pc_q);

  always_comb begin
    victim    = '0;
    found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[fill_set][w]) begin
        found_inv = 1'b1;
        victim    = WAY_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[fill_set][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
    end
  end

  // Outputs
  assign pc_ready      = !reset && (state_q == S_RUN) && !flush && (!out_valid_q || out_ready);
  assign accept        = pc_valid && pc_ready;
  assign mem_req_valid = (state_q == S_MISS_REQ);
  assign mem_req_addr  = {pc_q[63:OFF_W], OFF_W'(0)};
  assign miss          = (state_q != S_RUN);
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_instr     = out_instr_q;
  assign out_count     = out_count_q;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_count_d  = out_count_q;
    inv_now      = 1'b0;
    fill_we      = 1'b0;
    fill_done    = 1'b0;
    lru_upd      = 1'b0;
    lru_set      = lk_set;
    lru_way      = lk_way;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (flush) out_valid_d = 1'b0;

    unique case (state_q)
      S_RUN: begin
        inv_now = inv_all;
        if (accept) begin
          // An invalidate in the same cycle wins, so the lookup is forced to miss.
          if (lk_hit && !inv_all) begin
            out_valid_d = 1'b1;
            out_pc_d    = {pc[63:2], 2'b00};
            out_instr_d = pick_instr;
            out_count_d = pick_cnt;
            lru_upd     = 1'b1;
          end else begin
            pc_d         = {pc[63:2], 2'b00};
            flush_pend_d = 1'b0;
            state_d      = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = S_MISS_FILL;
        end
      end
      S_MISS_FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_resp_valid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            fill_done = 1'b1;
            lru_upd   = 1'b1;
            lru_set   = fill_set;
            lru_way   = victim;
            // A flushed miss still installs the line but skips the replay bundle.
            state_d   = (flush_pend_q || flush) ? S_RUN : S_REPLAY;
          end
        end
      end
      S_REPLAY: begin
        if (!flush) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_instr_d = pick_instr;
          out_count_d = pick_cnt;
        end
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      pc_q         <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_count_q  <= out_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (inv_now) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill_done) begin
      valid_q[fill_set][victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_we)   data_q[victim][fill_set][beat_q] <= mem_resp_data;
      if (fill_done) tag_q[victim][fill_set] <= tag_of(pc_q);
    end
  end

  // True LRU: touched way becomes 0, ways younger than its old age step up by one.
  if (WAYS > 1) begin : g_lru
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end else if (lru_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == lru_way)
            age_q[lru_set][w] <= '0;
          else if (age_q[lru_set][w] < age_q[lru_set][lru_way])
            age_q[lru_set][w] <= age_q[lru_set][w] + AGE_W'(1);
        end
      end
    end
  end else begin : g_no_lru
    always_comb begin
      for (int s = 0; s < SETS; s++) age_q[s][0] = '0;
    end
  end

endmodule
